// File: rtl/fetch_next_pc_pkg.sv
// fetch_next_pc_pkg: shared ISA constants and immediate decoders for the fetch stage
package fetch_next_pc_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_J_JAL  = 7'b1101111;
    localparam logic [6:0] OP_J_JALR = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] i);
        return {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] i);
        return {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // x1 and x5 are the conventional link registers
    function automatic logic is_link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

endpackage

// File: rtl/fetch_next_pc_bht_bimodal.sv
// bht_bimodal: array of 2-bit saturating direction counters with one read and one update port
module bht_bimodal #(
    parameter int ENTRIES = 64,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_ctr,
    input  logic          upd_valid,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    logic [1:0] ctr [ENTRIES];

    assign rd_ctr = ctr[rd_idx];

    // weakly-not-taken at reset; saturating train on resolved branches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
        end else if (upd_valid) begin
            ctr[upd_idx] <= upd_taken ? ((ctr[upd_idx] == 2'b11) ? 2'b11 : ctr[upd_idx] + 2'd1)
                                      : ((ctr[upd_idx] == 2'b00) ? 2'b00 : ctr[upd_idx] - 2'd1);
        end
    end

endmodule

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: PC register, instruction predecode and next-PC prediction for the fetch stage
module fetch_next_pc
    import fetch_next_pc_pkg::*;
#(
    parameter int              BHT_ENTRIES = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            bht_upd_valid,
    input  logic [XLEN-1:0] bht_upd_pc,
    input  logic            bht_upd_taken,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    output logic            ras_push_en,
    output logic            ras_pop_en,
    output logic [XLEN-1:0] ras_return_addr,
    output logic [6:0]      ras_opcode,
    output logic [4:0]      ras_rd,
    output logic [4:0]      ras_rs1,
    output logic            ras_flush,
    input  logic [XLEN-1:0] ras_top_addr,
    input  logic            ras_valid
);

    localparam int BI = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_plus4, pred_target;
    logic            pred_taken, fire, is_jal, is_jalr, is_br;
    logic [1:0]      bht_ctr;
    logic            unused_upd;

    assign pc_plus4        = pc_q + XLEN'(4);
    assign is_jal          = imem_rdata[6:0] == OP_J_JAL;
    assign is_jalr         = imem_rdata[6:0] == OP_J_JALR;
    assign is_br           = imem_rdata[6:0] == OP_BRANCH;
    assign fire            = state_q == RUN && !stall && !redirect_valid;
    assign imem_addr       = pc_q;
    assign ras_push_en     = fire && (is_jal || is_jalr);
    assign ras_pop_en      = fire && (is_jal || is_jalr);
    assign ras_return_addr = pc_plus4;
    assign ras_opcode      = imem_rdata[6:0];
    assign ras_rd          = imem_rdata[11:7];
    assign ras_rs1         = imem_rdata[19:15];
    assign ras_flush       = redirect_valid;
    assign unused_upd      = ^{bht_upd_pc[XLEN-1:BI+2], bht_upd_pc[1:0]};

    bht_bimodal #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_idx    (pc_q[BI+1:2]),
        .rd_ctr    (bht_ctr),
        .upd_valid (bht_upd_valid),
        .upd_idx   (bht_upd_pc[BI+1:2]),
        .upd_taken (bht_upd_taken)
    );

    // BOOT and BUBBLE each cost one fetch slot; a redirect always lands in BUBBLE
    always_comb begin
        state_d = state_q;
        if (redirect_valid) state_d = BUBBLE;
        else if (state_q != RUN) state_d = RUN;
    end

    // predict the next PC from the instruction currently returned by imem
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (is_jal) begin
            pred_taken  = 1'b1;
            pred_target = pc_q + imm_j(imem_rdata);
        end else if (is_br && bht_ctr[1]) begin
            pred_taken  = 1'b1;
            pred_target = pc_q + imm_b(imem_rdata);
        end else if (is_jalr && is_link(ras_rs1) && !is_link(ras_rd) && ras_valid) begin
            pred_taken  = 1'b1;
            pred_target = ras_top_addr;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= BOOT;
        else state_q <= state_d;
    end

    // PC and fetch-to-decode register; redirect beats stall, stall freezes everything else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q           <= RESET_PC;
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instr       <= '0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~XLEN'(3);
            if_valid <= 1'b0;
        end else if (state_q != RUN) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            pc_q           <= pred_target;
            if_valid       <= 1'b1;
            if_pc          <= pc_q;
            if_instr       <= imem_rdata;
            if_pred_taken  <= pred_taken;
            if_pred_target <= pred_target;
        end
    end

endmodule

// File: tb/tb_fetch_next_pc.sv
// tb_fetch_next_pc: randomized fetch traffic checked against a behavioural next-PC model via a scoreboard
module tb_fetch_next_pc;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [6:0]  JAL = 7'h6f, JALR = 7'h67, BR = 7'h63;

    logic        clk = 1'b0, reset_n, stall, redirect_valid, bht_upd_valid, bht_upd_taken, ras_valid;
    logic [31:0] redirect_pc, bht_upd_pc, imem_addr, imem_rdata, if_pc, if_instr, if_pred_target;
    logic [31:0] ras_return_addr, ras_top_addr;
    logic        if_valid, if_pred_taken, ras_push_en, ras_pop_en, ras_flush;
    logic [6:0]  ras_opcode;
    logic [4:0]  ras_rd, ras_rs1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [256];
    int          cnt [64];
    int          n_checks = 0, n_fail = 0;
    logic [31:0] m_pc;
    bit          m_idle, m_valid;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:2]];

    fetch_next_pc #(.BHT_ENTRIES(64), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ras_push_en(ras_push_en), .ras_pop_en(ras_pop_en), .ras_return_addr(ras_return_addr),
        .ras_opcode(ras_opcode), .ras_rd(ras_rd), .ras_rs1(ras_rs1), .ras_flush(ras_flush),
        .ras_top_addr(ras_top_addr), .ras_valid(ras_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] jimm(input logic [31:0] i);
        int v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
        if (i[31]) v -= 1 << 20;
        return 32'(v);
    endfunction

    function automatic logic [31:0] bimm(input logic [31:0] i);
        int v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048;
        if (i[31]) v -= 1 << 12;
        return 32'(v);
    endfunction

    function automatic bit link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_idle = 1'b1;
        m_valid = 1'b0;
        for (int i = 0; i < 64; i++) cnt[i] = 1;
        sb.delete();
    endtask

    task automatic check_reset();
        chk("rst if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst imem_addr", imem_addr, RST_PC);
        chk("rst ras_push_pop", {30'b0, ras_push_en, ras_pop_en}, 32'd0);
    endtask

    // monitor: decode consumes an instruction when it is valid and not stalled; a redirect squashes it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && if_valid && (!stall || redirect_valid)) begin
                if (sb.size() == 0) begin
                    chk("sb underflow if_pc", if_pc, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", if_instr, e.instr);
                    chk("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, e.taken});
                    chk("if_pred_target", if_pred_target, e.target);
                end
            end
        end
    end

    // stimulus + reference model
    initial begin
        logic [31:0] instr, tgt, r;
        logic [4:0]  rd, rs1;
        logic [6:0]  op;
        bit          fire, tk, call;
        int          idx;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0, 1:    r[6:0] = JAL;
                2, 3: begin
                    r[6:0] = JALR;
                    r[19:15] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : ($urandom_range(0, 1) ? 5'd1 : 5'd5);
                    r[11:7] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
                end
                4, 5, 6: r[6:0] = BR;
                default: r[6:0] = 7'h13;
            endcase
            mem[i] = r;
        end
        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bht_upd_valid = 1'b0;
        bht_upd_pc = '0;
        bht_upd_taken = 1'b0;
        ras_valid = 1'b0;
        ras_top_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                reset_n = 1'b0;
                #1;
                check_reset();
                model_reset();
                reset_n = 1'b1;
            end
            chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
            stall          = $urandom_range(0, 3) == 0;
            redirect_valid = $urandom_range(0, 15) == 0;
            redirect_pc    = $urandom;
            bht_upd_valid  = $urandom_range(0, 1);
            bht_upd_pc     = $urandom_range(0, 1) ? m_pc : $urandom;
            bht_upd_taken  = $urandom_range(0, 1);
            ras_valid      = $urandom_range(0, 1);
            ras_top_addr   = $urandom & ~32'd3;
            #1;
            instr = mem[m_pc[9:2]];
            op = instr[6:0];
            rd = instr[11:7];
            rs1 = instr[19:15];
            fire = !m_idle && !stall && !redirect_valid;
            call = op == JAL || op == JALR;
            tk = 1'b0;
            tgt = m_pc + 32'd4;
            if (op == JAL) begin
                tk = 1'b1;
                tgt = m_pc + jimm(instr);
            end else if (op == BR && cnt[m_pc[7:2]] >= 2) begin
                tk = 1'b1;
                tgt = m_pc + bimm(instr);
            end else if (op == JALR && link(rs1) && !link(rd) && ras_valid) begin
                tk = 1'b1;
                tgt = ras_top_addr;
            end
            chk("ras_push_en", {31'b0, ras_push_en}, {31'b0, fire && call});
            chk("ras_pop_en", {31'b0, ras_pop_en}, {31'b0, fire && call});
            chk("ras_flush", {31'b0, ras_flush}, {31'b0, redirect_valid});
            chk("ras_return_addr", ras_return_addr, m_pc + 32'd4);
            chk("ras_fields", {15'b0, ras_opcode, ras_rd, ras_rs1}, {15'b0, op, rd, rs1});
            if (fire) sb.push_back('{pc: m_pc, instr: instr, taken: tk, target: tgt});
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'd3;
                m_idle = 1'b1;
                m_valid = 1'b0;
            end else if (m_idle) begin
                m_idle = 1'b0;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_pc = tgt;
                m_valid = 1'b1;
            end
            if (bht_upd_valid) begin
                idx = int'(bht_upd_pc[7:2]);
                cnt[idx] = bht_upd_taken ? ((cnt[idx] < 3) ? cnt[idx] + 1 : 3) : ((cnt[idx] > 0) ? cnt[idx] - 1 : 0);
            end
            @(posedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
